// File: rtl/dm_sba_master_if.sv
// dm_sba_master_if: system bus request/response channel between the SBA master and the bus
//   master modport : drives bus_req_o/bus_we_o/bus_addr_o/bus_wdata_o/bus_size_o, receives gnt/rvalid/rdata/err
//   slave modport  : the mirror view for the bus side
interface dm_sba_master_if;
   logic        bus_req_o;
   logic        bus_we_o;
   logic [31:0] bus_addr_o;
   logic [31:0] bus_wdata_o;
   logic [2:0]  bus_size_o;
   logic        bus_gnt_i;
   logic        bus_rvalid_i;
   logic [31:0] bus_rdata_i;
   logic        bus_err_i;
   modport master (
      output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_size_o,
      input  bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i
   );
   modport slave (
      input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_size_o,
      output bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i
   );
endinterface

// File: rtl/dm_sba_master.sv
// dm_sba_master: debug-module system bus access master (sbcs/sbaddress0/sbdata0, 32-bit accesses)
//   clk, rst (async, active-low), test_mode (DFT strap, unused functionally)
//   reg_valid_i/reg_write_i/reg_addr_i/reg_wdata_i : DM register access, reg_rdata_o combinational read data
//   bus : system bus master port (request held until grant, one response per request)
module dm_sba_master (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  test_mode,
   input  logic                  reg_valid_i,
   input  logic                  reg_write_i,
   input  logic [6:0]            reg_addr_i,
   input  logic [31:0]           reg_wdata_i,
   output logic [31:0]           reg_rdata_o,
   dm_sba_master_if.master       bus
);
   typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;
   state_t      state;
   logic        sbbusyerror, sbreadonaddr, sbautoincrement, sbreadondata;
   logic [2:0]  sbaccess, sberror;
   logic [31:0] sbaddress0, sbdata0;
   logic        sbbusy, wr_cs, wr_addr, wr_data, rd_data, blocked, trig;
   logic [31:0] trig_addr, trig_data, sbcs;
   logic        unused;
   assign unused = test_mode;
   assign sbbusy = state != IDLE;
   assign wr_cs = reg_valid_i & reg_write_i & (reg_addr_i == 7'h38);
   assign wr_addr = reg_valid_i & reg_write_i & (reg_addr_i == 7'h39);
   assign wr_data = reg_valid_i & reg_write_i & (reg_addr_i == 7'h3C);
   assign rd_data = reg_valid_i & ~reg_write_i & (reg_addr_i == 7'h3C);
   // a sticky error, or an access already in flight, suppresses any new trigger
   assign blocked = sbbusy | (sberror != 3'd0) | sbbusyerror;
   assign trig = ~blocked & ((wr_addr & sbreadonaddr) | wr_data | (rd_data & sbreadondata));
   // the access uses the value being written in the trigger cycle
   assign trig_addr = wr_addr ? reg_wdata_i : sbaddress0;
   assign trig_data = wr_data ? reg_wdata_i : sbdata0;
   assign sbcs = {3'd1, 6'd0, sbbusyerror, sbbusy, sbreadonaddr, sbaccess, sbautoincrement,
                  sbreadondata, sberror, 7'd32, 2'd0, 1'b1, 2'd0};
   assign bus.bus_size_o = 3'd2;
   always_comb
      reg_rdata_o = (reg_addr_i == 7'h38) ? sbcs :
                    (reg_addr_i == 7'h39) ? sbaddress0 :
                    (reg_addr_i == 7'h3C) ? sbdata0 : 32'd0;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= IDLE;
         sbbusyerror     <= 1'b0;
         sbreadonaddr    <= 1'b0;
         sbautoincrement <= 1'b0;
         sbreadondata    <= 1'b0;
         sbaccess        <= 3'd0;
         sberror         <= 3'd0;
         sbaddress0      <= 32'd0;
         sbdata0         <= 32'd0;
         bus.bus_req_o   <= 1'b0;
         bus.bus_we_o    <= 1'b0;
         bus.bus_addr_o  <= 32'd0;
         bus.bus_wdata_o <= 32'd0;
      end else begin
         if (wr_cs) begin
            sbreadonaddr    <= reg_wdata_i[20];
            sbaccess        <= reg_wdata_i[19:17];
            sbautoincrement <= reg_wdata_i[16];
            sbreadondata    <= reg_wdata_i[15];
            sbbusyerror     <= sbbusyerror & ~reg_wdata_i[22];
            sberror         <= sberror & ~reg_wdata_i[14:12];
         end
         if (sbbusy & (wr_addr | wr_data | rd_data))
            sbbusyerror <= 1'b1;
         if (~sbbusy & wr_addr)
            sbaddress0 <= reg_wdata_i;
         if (~sbbusy & wr_data)
            sbdata0 <= reg_wdata_i;
         if (trig) begin
            if (sbaccess != 3'd2)
               sberror <= 3'd4;
            else if (trig_addr[1:0] != 2'd0)
               sberror <= 3'd3;
            else begin
               state           <= REQ;
               bus.bus_req_o   <= 1'b1;
               bus.bus_we_o    <= wr_data;
               bus.bus_addr_o  <= trig_addr;
               bus.bus_wdata_o <= trig_data;
            end
         end
         if (state == REQ && bus.bus_gnt_i) begin
            state         <= RSP;
            bus.bus_req_o <= 1'b0;
         end else if (state == RSP && bus.bus_rvalid_i) begin
            state <= IDLE;
            if (bus.bus_err_i)
               sberror <= 3'd2;
            else begin
               if (!bus.bus_we_o)
                  sbdata0 <= bus.bus_rdata_i;
               if (sbautoincrement)
                  sbaddress0 <= sbaddress0 + 32'd4;
            end
         end
      end
   end
endmodule

// File: tb/tb_dm_sba_master.sv
// tb_dm_sba_master: directed bench with a transaction-level model of the SBA register file and bus
module tb_dm_sba_master;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        test_mode = 1'b0;
   logic        reg_valid_i = 1'b0;
   logic        reg_write_i = 1'b0;
   logic [6:0]  reg_addr_i = 7'd0;
   logic [31:0] reg_wdata_i = 32'd0;
   logic [31:0] reg_rdata_o;
   int          errors = 0;
   int          checks = 0;
   dm_sba_master_if bus();
   dm_sba_master dut (
      .clk(clk), .rst(rst), .test_mode(test_mode),
      .reg_valid_i(reg_valid_i), .reg_write_i(reg_write_i),
      .reg_addr_i(reg_addr_i), .reg_wdata_i(reg_wdata_i),
      .reg_rdata_o(reg_rdata_o), .bus(bus)
   );
   always #5 clk = ~clk;
   // model state: register contents plus the outstanding bus request
   logic        m_be, m_busy, m_roa, m_ai, m_rod, m_req, m_we;
   logic [2:0]  m_acc, m_err;
   logic [31:0] m_addr, m_data, m_baddr, m_bwdata;
   task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask
   function automatic void m_reset();
      {m_be, m_busy, m_roa, m_ai, m_rod, m_req, m_we} = '0;
      m_acc = 0; m_err = 0; m_addr = 0; m_data = 0; m_baddr = 0; m_bwdata = 0;
   endfunction
   function automatic logic [31:0] m_read(logic [6:0] a);
      logic [31:0] cs;
      cs = 32'h2000_0404;
      cs[22] = m_be; cs[21] = m_busy; cs[20] = m_roa; cs[19:17] = m_acc;
      cs[16] = m_ai; cs[15] = m_rod; cs[14:12] = m_err;
      return a == 7'h38 ? cs : a == 7'h39 ? m_addr : a == 7'h3C ? m_data : 32'd0;
   endfunction
   function automatic void m_trigger(logic we);
      if (m_err != 0 || m_be) return;
      if (m_acc != 3'd2) m_err = 3'd4;
      else if (m_addr[1:0] != 2'd0) m_err = 3'd3;
      else begin
         m_busy = 1; m_req = 1; m_we = we; m_baddr = m_addr; m_bwdata = m_data;
      end
   endfunction
   task automatic reg_wr(logic [6:0] a, logic [31:0] d);
      reg_valid_i = 1; reg_write_i = 1; reg_addr_i = a; reg_wdata_i = d;
      @(posedge clk); #1;
      reg_valid_i = 0; reg_write_i = 0;
      if (a == 7'h38) begin
         m_roa = d[20]; m_acc = d[19:17]; m_ai = d[16]; m_rod = d[15];
         m_be = m_be & ~d[22]; m_err = m_err & ~d[14:12];
      end else if (a == 7'h39 || a == 7'h3C) begin
         if (m_busy) m_be = 1;
         else if (a == 7'h39) begin
            m_addr = d;
            if (m_roa) m_trigger(0);
         end else begin
            m_data = d;
            m_trigger(1);
         end
      end
   endtask
   task automatic reg_rd(logic [6:0] a, logic [31:0] exp, string n);
      reg_valid_i = 1; reg_write_i = 0; reg_addr_i = a;
      #1 chk(n, reg_rdata_o, exp);
      chk({n, "_model"}, reg_rdata_o, m_read(a));
      @(posedge clk); #1;
      reg_valid_i = 0;
      if (a == 7'h3C) begin
         if (m_busy) m_be = 1;
         else if (m_rod) m_trigger(0);
      end
   endtask
   task automatic idle(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic grant(int n);
      idle(n);
      bus.bus_gnt_i = 1;
      @(posedge clk); #1;
      bus.bus_gnt_i = 0;
      m_req = 0;
   endtask
   task automatic respond(logic [31:0] d, logic e);
      bus.bus_rvalid_i = 1; bus.bus_rdata_i = d; bus.bus_err_i = e;
      @(posedge clk); #1;
      bus.bus_rvalid_i = 0; bus.bus_err_i = 0;
      if (m_busy) begin
         m_busy = 0;
         if (e) m_err = 3'd2;
         else begin
            if (!m_we) m_data = d;
            if (m_ai) m_addr = m_addr + 32'd4;
         end
      end
   endtask
   // bus outputs checked against the model on every cycle
   always @(negedge clk) begin
      chk("bus_req", bus.bus_req_o, m_req);
      chk("bus_size", bus.bus_size_o, 3'd2);
      if (m_req) begin
         chk("bus_we", bus.bus_we_o, m_we);
         chk("bus_addr", bus.bus_addr_o, m_baddr);
         chk("bus_wdata", bus.bus_wdata_o, m_bwdata);
      end
   end
   initial begin
      bus.bus_gnt_i = 0; bus.bus_rvalid_i = 0; bus.bus_rdata_i = 0; bus.bus_err_i = 0;
      m_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1;
      reg_rd(7'h38, 32'h2000_0404, "rst_sbcs");
      reg_rd(7'h39, 32'h0, "rst_addr");
      reg_rd(7'h3C, 32'h0, "rst_data");
      reg_rd(7'h10, 32'h0, "unmapped");
      // read on address write, grant after 2 cycles
      reg_wr(7'h38, 32'h0014_0000);
      reg_wr(7'h39, 32'h0000_1000);
      reg_rd(7'h38, 32'h2034_0404, "busy_sbcs");
      grant(2);
      respond(32'hCAFE_F00D, 0);
      reg_rd(7'h3C, 32'hCAFE_F00D, "rd_data");
      reg_rd(7'h38, 32'h2014_0404, "idle_sbcs");
      // write with autoincrement wrapping the address
      reg_wr(7'h38, 32'h0005_0000);
      reg_wr(7'h39, 32'hFFFF_FFFC);
      reg_wr(7'h3C, 32'h5A5A_5A5A);
      chk("wr_we", bus.bus_we_o, 1);
      chk("wr_addr", bus.bus_addr_o, 32'hFFFF_FFFC);
      chk("wr_wdata", bus.bus_wdata_o, 32'h5A5A_5A5A);
      grant(0);
      respond(32'h0, 0);
      reg_rd(7'h39, 32'h0, "wrap_addr");
      reg_rd(7'h3C, 32'h5A5A_5A5A, "wr_data_kept");
      // busy error
      reg_wr(7'h3C, 32'h1111_1111);
      reg_wr(7'h3C, 32'h2222_2222);
      grant(1);
      respond(32'h0, 0);
      reg_rd(7'h3C, 32'h1111_1111, "busy_data");
      reg_rd(7'h38, 32'h2045_0404, "busyerr_sbcs");
      reg_wr(7'h3C, 32'h3333_3333);
      idle(2);
      reg_rd(7'h3C, 32'h3333_3333, "blocked_data");
      reg_wr(7'h38, 32'h0045_0000);
      reg_rd(7'h38, 32'h2005_0404, "busyerr_clr");
      reg_wr(7'h3C, 32'h4444_4444);
      chk("retry_addr", bus.bus_addr_o, 32'h4);
      grant(0);
      respond(32'h0, 0);
      reg_rd(7'h39, 32'h8, "inc_addr");
      // alignment and size errors
      reg_wr(7'h38, 32'h0014_0000);
      reg_wr(7'h39, 32'h0000_1002);
      idle(2);
      reg_rd(7'h38, 32'h2014_3404, "align_err");
      reg_rd(7'h39, 32'h0000_1002, "align_addr");
      reg_wr(7'h38, 32'h0010_7000);
      reg_wr(7'h39, 32'h0000_2000);
      reg_rd(7'h38, 32'h2010_4404, "size_err");
      // bus error response
      reg_wr(7'h38, 32'h0015_7000);
      reg_wr(7'h39, 32'h0000_3000);
      grant(1);
      respond(32'h9999_9999, 1);
      reg_rd(7'h38, 32'h2015_2404, "bus_err");
      reg_rd(7'h39, 32'h0000_3000, "err_no_inc");
      reg_rd(7'h3C, 32'h4444_4444, "err_no_data");
      reg_wr(7'h38, 32'h0000_7000);
      reg_rd(7'h38, 32'h2000_0404, "err_clr");
      // read on data read, returns the old value first
      reg_wr(7'h38, 32'h0004_8000);
      reg_wr(7'h39, 32'h0000_0040);
      reg_rd(7'h3C, 32'h4444_4444, "rod_first");
      grant(0);
      respond(32'hDEAD_BEEF, 0);
      reg_rd(7'h3C, 32'hDEAD_BEEF, "rod_second");
      grant(3);
      respond(32'h1234_5678, 0);
      reg_wr(7'h38, 32'h0004_0000);
      reg_rd(7'h3C, 32'h1234_5678, "rod_third");
      // reset mid-request, then a stray response
      reg_wr(7'h38, 32'h0014_0000);
      reg_wr(7'h39, 32'h0000_5000);
      idle(1);
      rst = 0;
      m_reset();
      #1 chk("rst_req", bus.bus_req_o, 0);
      chk("rst_baddr", bus.bus_addr_o, 0);
      reg_rd(7'h39, 32'h0, "rst_mid_addr");
      rst = 1;
      respond(32'hBAD0_BAD0, 0);
      reg_rd(7'h3C, 32'h0, "late_rvalid");
      reg_rd(7'h38, 32'h2000_0404, "late_sbcs");
      idle(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/dm_sba_master.md
DM_SBA_MASTER -- requirements
Module: dm_sba_master

Interface
REQ-001 The block SHALL have no parameters: data and address fixed at 32 bits, 32-bit access only.
REQ-002 clk  in  1  system clock; all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low (asserted when 0).
REQ-004 test_mode  in  1  DFT strap; no functional effect.
REQ-005 reg_valid_i  in  1  DM register access strobe, one cycle per access.
REQ-006 reg_write_i  in  1  1=write, 0=read.
REQ-007 reg_addr_i  in  7  DMI address; 0x38 sbcs, 0x39 sbaddress0, 0x3C sbdata0, others ignored.
REQ-008 reg_wdata_i  in  32  write data.
REQ-009 reg_rdata_o  out  32  read data, combinational from reg_addr_i; 0 for unmapped addresses.
REQ-010 bus_req_o  out  1  system bus request.
REQ-011 bus_we_o, bus_addr_o[31:0], bus_wdata_o[31:0], bus_size_o[2:0]  out  request attributes; bus_size_o constant 3'd2.
REQ-012 bus_gnt_i  in  1  request accepted this cycle.
REQ-013 bus_rvalid_i, bus_rdata_i[31:0], bus_err_i  in  response strobe, read data, error qualifier.

Function
REQ-014 sbcs SHALL read {sbversion[31:29]=1, sbbusyerror[22], sbbusy[21], sbreadonaddr[20], sbaccess[19:17], sbautoincrement[16], sbreadondata[15], sberror[14:12], sbasize[11:5]=32, sbaccess32[2]=1}, other bits 0.
REQ-015 sbcs write SHALL load sbreadonaddr, sbaccess, sbautoincrement, sbreadondata; sbbusyerror and sberror SHALL be write-1-to-clear.
REQ-016 FSM states SHALL be IDLE, REQ, RSP; sbbusy=1 in REQ and RSP.
REQ-017 Read trigger: sbaddress0 write with sbreadonaddr=1, or sbdata0 read with sbreadondata=1 (returns current sbdata0 first).
REQ-018 Write trigger: sbdata0 write (sbdata0 updated, then access issued).
REQ-019 Triggers SHALL be ignored while sberror!=0 or sbbusyerror=1; register updates still apply when not busy.
REQ-020 While sbbusy=1, any sbaddress0 write, sbdata0 write or sbdata0 read SHALL set sbbusyerror=1 and leave sbaddress0/sbdata0 unchanged, no new access.
REQ-021 On trigger with sbaccess!=2: sberror=4, no bus activity, stay IDLE.
REQ-022 On trigger with sbaddress0[1:0]!=0: sberror=3, no bus activity, stay IDLE.
REQ-023 Valid trigger: IDLE->REQ on next edge; bus_req_o=1 first cycle after trigger cycle.
REQ-024 In REQ, bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o SHALL be held stable until bus_gnt_i=1; then REQ->RSP, bus_req_o=0 next cycle.
REQ-025 In RSP, on bus_rvalid_i=1: bus_err_i=1 -> sberror=2, no data/address update; else read captures bus_rdata_i into sbdata0; then RSP->IDLE.
REQ-026 bus_rvalid_i outside RSP SHALL be ignored; gnt and rvalid in the same cycle are not supported by the bus.
REQ-027 On successful completion with sbautoincrement=1, sbaddress0 += 4 modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-028 sbcs accesses SHALL be accepted in any state; clearing sberror while busy does not abort the access.

Reset
REQ-029 On rst=0, immediately: state IDLE, bus_req_o=0, bus_we_o=0, bus_addr_o=0, bus_wdata_o=0, sbaddress0=0, sbdata0=0, all writable sbcs fields 0.
REQ-030 Reset mid-access SHALL abandon the transaction; a late bus_rvalid_i after reset SHALL have no effect.

Verification
REQ-031 sbcs=0x00140000 (readonaddr, access=2), write sbaddress0=0x1000, gnt after 2 cycles, rvalid rdata=0xCAFEF00D -> sbdata0=0xCAFEF00D, sbbusy returns 0.
REQ-032 sbcs autoincrement=1, sbaddress0=0xFFFFFFFC, write sbdata0=0x5A5A5A5A -> bus_we_o=1, addr 0xFFFFFFFC, wdata 0x5A5A5A5A; after rvalid sbaddress0=0.
REQ-033 Write sbdata0 while sbbusy=1 -> sbbusyerror=1, sbdata0 unchanged; next trigger ignored until sbcs written with bit22=1.
REQ-034 sbaddress0=0x1002 with readonaddr -> sberror=3, bus_req_o never asserts; sbaccess=0 trigger -> sberror=4.
REQ-035 rvalid with bus_err_i=1 -> sberror=2, sbaddress0 not incremented; W1C 0x7000 to sbcs -> sberror=0.
REQ-036 rst=0 while bus_req_o=1 -> bus_req_o=0 same cycle, all registers reset values.
